div_wb_unit: RTL

- Iterative 32-bit integer divider that runs in parallel with the single-cycle datapath.
- Feeds its result into the register-file write port (RegW/Dir/Din) through a request/grant writeback slot.
- Main pipeline always has write-port priority; the divider holds its request until granted.
- Exposes busy/destination for the hazard/stall logic.

---
 rtl/div_wb_unit_pkg.sv | 13 +
 rtl/div_wb_unit_step.sv | 19 +
 rtl/div_wb_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_wb_unit_pkg.sv
// div_wb_unit_pkg: shared widths, state encoding and divide-by-zero constant for the divider writeback unit
package div_wb_unit_pkg;
  localparam int WIDTH = 32;
  localparam int AW = 5;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    WB   = 2'd3
  } state_e;
  localparam logic [WIDTH-1:0] DIV0_QUO = '1;
endpackage

// File: rtl/div_wb_unit_step.sv
// div_step: one restoring-division iteration on {rem, quo}
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] sh;
  logic ge;
  always_comb begin
    sh = {rem_in, quo_in[WIDTH-1]};
    ge = sh >= {1'b0, divisor};
    rem_out = ge ? sh[WIDTH-1:0] - divisor : sh[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/div_wb_unit.sv
// div_wb_unit: iterative signed/unsigned divider that writes its result back through a request/grant register-file slot
module div_wb_unit
  import div_wb_unit_pkg::*;
#(
  parameter int WIDTH = div_wb_unit_pkg::WIDTH,
  parameter int CNT_W = div_wb_unit_pkg::CNT_W,
  parameter int AW    = div_wb_unit_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_en,
  input  logic             op_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [AW-1:0]    dest,
  input  logic             wb_grant,
  output logic             busy,
  output logic [AW-1:0]    busy_dest,
  output logic             RegW,
  output logic [AW-1:0]    Dir,
  output logic [WIDTH-1:0] Din
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, din_q, din_d;
  logic [AW-1:0] dest_q, dest_d, dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic op_rem_q, op_rem_d, qneg_q, qneg_d, rneg_q, rneg_d, regw_q, regw_d;
  logic [WIDTH-1:0] rem_nx, quo_nx, dvd_abs, dvs_abs, q_fix, r_fix;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(rem_nx),
    .quo_out(quo_nx)
  );
  always_comb begin
    dvd_abs = (sign_en && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (sign_en && divisor[WIDTH-1]) ? -divisor : divisor;
    q_fix = qneg_q ? -quo_q : quo_q;
    r_fix = rneg_q ? -rem_q : rem_q;
  end
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    din_d = din_q;
    dest_d = dest_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    op_rem_d = op_rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    regw_d = regw_q;
    case (state_q)
      IDLE: if (start) begin
        op_rem_d = op_rem;
        dest_d = dest;
        cnt_d = '0;
        dvs_d = dvs_abs;
        // a zero divisor bypasses iteration and sign fixup entirely
        if (divisor == '0) begin
          rem_d = dividend;
          quo_d = DIV0_QUO;
          qneg_d = 1'b0;
          rneg_d = 1'b0;
          state_d = FIX;
        end else begin
          rem_d = '0;
          quo_d = dvd_abs;
          qneg_d = sign_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = sign_en & dividend[WIDTH-1];
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : BUSY;
      end
      FIX: if (dest_q != '0) begin
        din_d = op_rem_q ? r_fix : q_fix;
        dir_d = dest_q;
        regw_d = 1'b1;
        state_d = WB;
      end else begin
        state_d = IDLE;
      end
      WB: if (wb_grant) begin
        regw_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      din_q <= '0;
      dest_q <= '0;
      dir_q <= '0;
      cnt_q <= '0;
      op_rem_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      regw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      din_q <= din_d;
      dest_q <= dest_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      op_rem_q <= op_rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      regw_q <= regw_d;
    end
  end
  assign busy = state_q != IDLE;
  assign busy_dest = busy ? dest_q : '0;
  assign RegW = regw_q;
  assign Dir = dir_q;
  assign Din = din_q;
endmodule
